tbcm_arbiter_requester: RTL

- Client-side agent for the matrix arbiter's request/grant/free interface; one instance per requester slot.
- Buffers an upstream valid/ready packet stream in a small FIFO and raises a request while data is waiting.
- Once granted, forwards beats onto the shared downstream channel and pulses free on the beat that ends the grant.
- Works with both held-grant and combinational arbiter configurations.

---
 rtl/tbcm_arbiter_requester_pkg.sv | 16 +
 rtl/tbcm_sync_fifo.sv | 41 ++++
 rtl/tbcm_arbiter_requester.sv | 79 +++++++
 3 files changed

// File: rtl/tbcm_arbiter_requester_pkg.sv
// Shared types for the arbiter requester agent: FSM encoding and the
// rule that decides which popped beat releases the grant.
package tbcm_arbiter_requester_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    GRANTED = 2'd2
  } tbcm_arbiter_requester_state;

  // Packet mode releases only on the last beat; beat mode releases on every beat.
  function automatic logic free_beat(input logic last, input logic free_on_last);
    return !free_on_last || last;
  endfunction

endpackage

// File: rtl/tbcm_sync_fifo.sv
// Single-clock FIFO with registered storage; the head is readable the cycle
// after its push, with no write-to-read bypass.
module tbcm_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  // Extra pointer MSB tells full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tbcm_arbiter_requester.sv
// Requester-side agent for the matrix arbiter: buffers upstream beats,
// requests the shared channel, forwards while granted and pulses free.
module tbcm_arbiter_requester
  import tbcm_arbiter_requester_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int FREE_ON_LAST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_request,
  input  logic                  i_grant,
  output logic                  o_free,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_busy
);
  tbcm_arbiter_requester_state state, state_nxt;

  logic full, empty, push, pop, grant_ok;
  logic [DATA_WIDTH:0] head;

  assign o_ready = !full;
  assign push    = i_valid && !full;

  tbcm_sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({i_last, i_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign o_last = head[DATA_WIDTH];
  assign o_data = head[DATA_WIDTH-1:0];

  // A grant seen in IDLE is ignored; REQUEST may forward in the grant cycle.
  assign grant_ok = (state != IDLE) && i_grant;
  assign o_valid  = grant_ok && !empty;
  assign pop      = o_valid && i_ready;
  assign o_free   = pop && free_beat(o_last, 1'(FREE_ON_LAST != 0));
  assign o_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_request = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = REQUEST;
      end
      REQUEST: begin
        o_request = 1'b1;
        if (o_free)       state_nxt = IDLE;
        else if (i_grant) state_nxt = GRANTED;
      end
      GRANTED: begin
        o_request = 1'b1;
        if (o_free) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
